click_decoder: RTL and testbench



---
 rtl/click_decoder_if.sv | 29 ++
 rtl/click_decoder.sv | 123 ++++++++++++
 tb/tb_click_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/click_decoder_if.sv
// -----------------------------------------------------------------------------
// click_decoder_if
// Valid/ready event channel carrying one decoded click group.
//   evt_valid    : event pending (producer -> consumer)
//   evt_ready    : consumer accepts the pending event this cycle
//   evt_count    : clicks in the group, 1..MAX_CLICKS, stable while evt_valid
//   evt_overflow : group saw more presses than MAX_CLICKS, stable while evt_valid
// Modports: master = event producer (click_decoder), slave = event consumer.
// -----------------------------------------------------------------------------
interface click_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       evt_overflow;

  modport master (
    output evt_valid,
    output evt_count,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    input  evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/click_decoder.sv
// -----------------------------------------------------------------------------
// click_decoder
// Groups single-cycle debounced press pulses that arrive within WINDOW idle
// cycles of each other into one click event (single/double/triple...), and
// hands each event downstream over a valid/ready channel.
// Ports:
//   clk     : system clock, posedge
//   rst_n   : asynchronous active-low reset
//   flag    : debounced press pulse, one cycle per press
//   dropped : one-cycle pulse, a press was discarded while an event was pending
//   evt     : event channel (master side): evt_valid/evt_count/evt_overflow out,
//             evt_ready in
// Parameters:
//   WINDOW     : max idle cycles between presses of one group (2..2^24-1)
//   MAX_CLICKS : saturation count per group (1..7)
// -----------------------------------------------------------------------------
module click_decoder #(
  parameter int WINDOW     = 10_000_000,
  parameter int MAX_CLICKS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag,
  output logic             dropped,
  click_decoder_if.master  evt
);

  localparam logic [23:0] LAST_TICK = 24'(WINDOW - 1);
  localparam logic [2:0]  MAX_CNT   = 3'(MAX_CLICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    PEND   = 2'd2
  } state_t;

  state_t      state_r;
  logic [23:0] timer_r;
  logic [2:0]  count_r;
  logic        overflow_r;
  logic        evt_valid_r;
  logic [2:0]  evt_count_r;
  logic        evt_overflow_r;
  logic        dropped_r;

  // Group-gathering FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      timer_r        <= 24'd0;
      count_r        <= 3'd0;
      overflow_r     <= 1'b0;
      evt_valid_r    <= 1'b0;
      evt_count_r    <= 3'd0;
      evt_overflow_r <= 1'b0;
      dropped_r      <= 1'b0;
    end else begin
      dropped_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flag) begin
            count_r    <= 3'd1;
            overflow_r <= 1'b0;
            timer_r    <= 24'd0;
            state_r    <= GATHER;
          end else begin
            state_r <= IDLE;
          end
        end

        GATHER: begin
          // A press always wins over window expiry in the same cycle.
          if (flag) begin
            if (count_r < MAX_CNT) begin
              count_r <= count_r + 3'd1;
            end else begin
              overflow_r <= 1'b1;
            end
            timer_r <= 24'd0;
          end else if (timer_r == LAST_TICK) begin
            state_r        <= PEND;
            timer_r        <= 24'd0;
            evt_valid_r    <= 1'b1;
            evt_count_r    <= count_r;
            evt_overflow_r <= overflow_r;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end

        PEND: begin
          // Presses while an event is outstanding are discarded, including
          // the accepting cycle, and never open a new group.
          if (flag) begin
            dropped_r <= 1'b1;
          end else begin
            dropped_r <= 1'b0;
          end
          if (evt.evt_ready) begin
            evt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= PEND;
          end
        end

        default: begin
          state_r     <= IDLE;
          timer_r     <= 24'd0;
          count_r     <= 3'd0;
          overflow_r  <= 1'b0;
          evt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign evt.evt_valid    = evt_valid_r;
  assign evt.evt_count    = evt_count_r;
  assign evt.evt_overflow = evt_overflow_r;
  assign dropped          = dropped_r;

endmodule

// File: tb/tb_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_click_decoder
// Directed bench for click_decoder with WINDOW=8, MAX_CLICKS=3. A flag driven
// before a posedge is sampled on that edge; outputs are read 1 time unit after
// the edge, so an event is expected 8 edges after the edge that sampled the
// last press of its group.
// -----------------------------------------------------------------------------
module tb_click_decoder;

  logic clk;
  logic rst_n;
  logic flag;
  logic dropped;

  int checks;
  int errors;

  click_decoder_if evt_if ();

  click_decoder #(
    .WINDOW     (8),
    .MAX_CLICKS (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag    (flag),
    .dropped (dropped),
    .evt     (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, let one posedge sample them, settle past the edge.
  task automatic tick(input logic f, input logic r);
    flag             = f;
    evt_if.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Idle ticks with no event expected.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1);
      check1(tag, evt_if.evt_valid, 1'b0);
    end
  endtask

  // After the last press of a group: no event for 7 edges, event on the 8th,
  // accepted on the 9th.
  task automatic expect_event(input logic [2:0] c, input logic o, input string tag);
    quiet(7, {tag, "_early"});
    tick(1'b0, 1'b1);
    check1({tag, "_valid"}, evt_if.evt_valid, 1'b1);
    check3({tag, "_count"}, evt_if.evt_count, c);
    check1({tag, "_ovf"}, evt_if.evt_overflow, o);
    tick(1'b0, 1'b1);
    check1({tag, "_accept"}, evt_if.evt_valid, 1'b0);
    check1({tag, "_nodrop"}, dropped, 1'b0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    flag             = 1'b0;
    evt_if.evt_ready = 1'b1;

    // Reset values before any clock edge.
    #3;
    check1("rst_valid", evt_if.evt_valid, 1'b0);
    check3("rst_count", evt_if.evt_count, 3'd0);
    check1("rst_ovf", evt_if.evt_overflow, 1'b0);
    check1("rst_drop", dropped, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet(3, "post_rst");

    // Single click.
    tick(1'b1, 1'b1);
    expect_event(3'd1, 1'b0, "single");
    quiet(2, "gap_a");

    // Double click, presses 5 edges apart.
    tick(1'b1, 1'b1);
    quiet(4, "dbl_mid");
    tick(1'b1, 1'b1);
    expect_event(3'd2, 1'b0, "double");
    quiet(2, "gap_b");

    // Five presses 3 edges apart: saturates at 3 with overflow.
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1);
      if (k < 4) quiet(2, "ovf_mid");
    end
    expect_event(3'd3, 1'b1, "overflow");
    quiet(2, "gap_c");

    // Second press 7 edges later, one before expiry.
    tick(1'b1, 1'b1);
    quiet(6, "late_mid");
    tick(1'b1, 1'b1);
    expect_event(3'd2, 1'b0, "late");
    quiet(2, "gap_d");

    // Second press exactly on the expiry edge: counted, no event.
    tick(1'b1, 1'b1);
    quiet(7, "expiry_mid");
    tick(1'b1, 1'b1);
    check1("expiry_noevt", evt_if.evt_valid, 1'b0);
    expect_event(3'd2, 1'b0, "expiry");
    quiet(2, "gap_e");

    // Back-pressure: ready low, presses while pending are dropped.
    tick(1'b1, 1'b0);                       // edge 10
    for (int i = 11; i <= 17; i++) begin
      tick(1'b0, 1'b0);
      check1("bp_early", evt_if.evt_valid, 1'b0);
    end
    tick(1'b0, 1'b0);                       // edge 18
    check1("bp_valid", evt_if.evt_valid, 1'b1);
    check3("bp_count", evt_if.evt_count, 3'd1);
    check1("bp_ovf", evt_if.evt_overflow, 1'b0);
    tick(1'b0, 1'b0);                       // edge 19
    check1("bp_nodrop19", dropped, 1'b0);
    tick(1'b1, 1'b0);                       // edge 20
    check1("bp_drop20", dropped, 1'b1);
    check1("bp_hold20", evt_if.evt_valid, 1'b1);
    for (int i = 21; i <= 39; i++) begin
      tick(1'b0, 1'b0);
      check1("bp_hold", evt_if.evt_valid, 1'b1);
      check3("bp_stable", evt_if.evt_count, 3'd1);
      check1("bp_drop_clr", dropped, 1'b0);
    end
    tick(1'b1, 1'b1);                       // edge 40: accept + drop
    check1("bp_accept", evt_if.evt_valid, 1'b0);
    check1("bp_drop40", dropped, 1'b1);
    tick(1'b0, 1'b1);                       // edge 41
    check1("bp_drop41", dropped, 1'b0);
    quiet(12, "bp_nosecond");

    // Asynchronous reset in the middle of a group.
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    check3("pre_rst_count", evt_if.evt_count, 3'd1);
    rst_n = 1'b0;
    #2;
    check1("arst_valid", evt_if.evt_valid, 1'b0);
    check3("arst_count", evt_if.evt_count, 3'd0);
    check1("arst_ovf", evt_if.evt_overflow, 1'b0);
    check1("arst_drop", dropped, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
    quiet(12, "arst_noevt");
    tick(1'b1, 1'b1);
    expect_event(3'd1, 1'b0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
